apb_req_arbiter: RTL and testbench

Round-robin scheduler that shares one APB master port among NUM_REQ independent requesters. It accepts one read or write request per transfer, drives the APB SETUP/ACCESS protocol, and returns the read data and error status to the winning requester. It also enforces a slave timeout. The block sits between the request sources (command FIFOs, CPU shims) and the APB slave fabric.

---
 rtl/apb_req_arbiter_if.sv | 38 +++
 rtl/apb_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Request/response and APB bus bundle for apb_req_arbiter.
// The master modport is the arbiter; the slave modport is whatever drives requests and models the APB slave.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_write_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      rsp_err_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [ADDR_W-1:0]         paddr_o;
    logic [DATA_W-1:0]         pwdata_o;
    logic [DATA_W-1:0]         prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with a saturating ACCESS-phase timeout that aborts a hung slave.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    apb_req_arbiter_if.master   bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 win_found_s;
    logic [PTR_W-1:0]     win_idx_s;
    logic [PTR_W-1:0]     cand_s;
    logic [NUM_REQ-1:0]   ready_s;

    // Round-robin winner search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found_s && bus.req_valid_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        ready_s     = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    ready_s[win_idx_s] = 1'b1;
                    owner_d   = win_idx_s;
                    pwrite_d  = bus.req_write_i[win_idx_s];
                    paddr_d   = bus.req_addr_i[int'(win_idx_s)*ADDR_W +: ADDR_W];
                    pwdata_d  = bus.req_wdata_i[int'(win_idx_s)*DATA_W +: DATA_W];
                    rr_ptr_d  = PTR_W'((int'(win_idx_s) + 1) % NUM_REQ);
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                cnt_d     = '0;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // Normal completion and timeout abort share the same wrap-up path.
                if (bus.pready_i || (cnt_q == CNT_LAST)) begin
                    state_d              = ST_IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = bus.pready_i ? bus.pslverr_i : 1'b1;
                    rsp_data_d           = (bus.pready_i && !pwrite_q && !bus.pslverr_i)
                                           ? bus.prdata_i : '0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset discards any in-flight transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = reset ? '0 : ready_s;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: inputs change and outputs are sampled around the falling edge.
module tb_apb_req_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    apb_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(32)) bus ();

    apb_req_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        bus.req_valid_i = 4'b1111;
        @(negedge clk); #1;
        checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready_o); end
        checks++; if ({bus.psel_o, bus.penable_o, bus.pwrite_o} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl got %b exp 000", {bus.psel_o, bus.penable_o, bus.pwrite_o}); end
        checks++; if ({bus.paddr_o, bus.pwdata_o} !== 42'd0) begin errors++; $display("FAIL reset_apb_data got %h exp 0", {bus.paddr_o, bus.pwdata_o}); end
        checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o} !== 37'd0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o}); end
        bus.req_valid_i = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.req_valid_i = 4'b0001; bus.req_write_i = 4'b0001;
        bus.req_addr_i[0 +: 10] = 10'h010; bus.req_wdata_i[0 +: 32] = 32'hA5A5_0001;
        bus.pready_i = 1'b1;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL wr_ready got %b exp 0001", bus.req_ready_o); end
        checks++; if ({bus.psel_o, bus.penable_o} !== 2'b00) begin errors++; $display("FAIL wr_idle_ctl got %b exp 00", {bus.psel_o, bus.penable_o}); end
        @(negedge clk); bus.req_valid_i = 4'b0000; #1;
        checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL wr_ready_pulse got %b exp 0000", bus.req_ready_o); end
        checks++; if ({bus.psel_o, bus.penable_o, bus.pwrite_o} !== 3'b101) begin errors++; $display("FAIL wr_setup_ctl got %b exp 101", {bus.psel_o, bus.penable_o, bus.pwrite_o}); end
        checks++; if (bus.paddr_o !== 10'h010) begin errors++; $display("FAIL wr_paddr got %h exp 010", bus.paddr_o); end
        checks++; if (bus.pwdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_pwdata got %h exp a5a50001", bus.pwdata_o); end
        @(negedge clk); #1;
        checks++; if ({bus.psel_o, bus.penable_o} !== 2'b11) begin errors++; $display("FAIL wr_access_ctl got %b exp 11", {bus.psel_o, bus.penable_o}); end
        checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL wr_early_rsp got %b exp 0000", bus.rsp_valid_o); end
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL wr_rsp_valid got %b exp 0001", bus.rsp_valid_o); end
        checks++; if ({bus.rsp_err_o, bus.rsp_data_o} !== 33'd0) begin errors++; $display("FAIL wr_rsp_data got %h exp 0", {bus.rsp_err_o, bus.rsp_data_o}); end
        checks++; if ({bus.psel_o, bus.penable_o} !== 2'b00) begin errors++; $display("FAIL wr_done_ctl got %b exp 00", {bus.psel_o, bus.penable_o}); end
    endtask

    task automatic test_read_wait();
        @(negedge clk);
        bus.req_valid_i = 4'b0100; bus.req_write_i = 4'b0000;
        bus.req_addr_i[20 +: 10] = 10'h20C; bus.pready_i = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL rd_ready got %b exp 0100", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 4'b0000; #1;
        checks++; if ({bus.psel_o, bus.penable_o, bus.pwrite_o} !== 3'b100) begin errors++; $display("FAIL rd_setup_ctl got %b exp 100", {bus.psel_o, bus.penable_o, bus.pwrite_o}); end
        checks++; if (bus.paddr_o !== 10'h20C) begin errors++; $display("FAIL rd_paddr got %h exp 20c", bus.paddr_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin bus.pready_i = 1'b1; bus.prdata_i = 32'hDEAD_BEEF; end
            #1;
            checks++; if ({bus.psel_o, bus.penable_o} !== 2'b11) begin errors++; $display("FAIL rd_access_%0d got %b exp 11", i, {bus.psel_o, bus.penable_o}); end
            checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL rd_wait_rsp_%0d got %b exp 0000", i, bus.rsp_valid_o); end
        end
        @(negedge clk); bus.pready_i = 1'b0; #1;
        checks++; if (bus.rsp_valid_o !== 4'b0100) begin errors++; $display("FAIL rd_rsp_valid got %b exp 0100", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_data got %h exp deadbeef", bus.rsp_data_o); end
        checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_rsp_err got %b exp 0", bus.rsp_err_o); end
        checks++; if (bus.penable_o !== 1'b0) begin errors++; $display("FAIL rd_penable_drop got %b exp 0", bus.penable_o); end
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL rd_rsp_once got %b exp 0000", bus.rsp_valid_o); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_s;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        bus.req_valid_i = 4'b1111; bus.req_write_i = 4'b1111; bus.pready_i = 1'b1;
        for (int g = 0; g < 8; g++) begin
            if (g > 0) begin @(negedge clk); end
            #1;
            exp_s = 4'b0001 << (g % 4);
            checks++; if (bus.req_ready_o !== exp_s) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", g, bus.req_ready_o, exp_s); end
            if (g > 0) begin
                exp_s = 4'b0001 << ((g - 1) % 4);
                checks++; if (bus.rsp_valid_o !== exp_s) begin errors++; $display("FAIL rr_rsp_%0d got %b exp %b", g, bus.rsp_valid_o, exp_s); end
            end
            for (int w = 0; w < 2; w++) begin
                @(negedge clk); #1;
                checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL rr_gap_%0d_%0d got %b exp 0000", g, w, bus.req_ready_o); end
            end
        end
        @(negedge clk); bus.req_valid_i = 4'b0000; #1;
        checks++; if (bus.rsp_valid_o !== 4'b1000) begin errors++; $display("FAIL rr_last_rsp got %b exp 1000", bus.rsp_valid_o); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        bus.req_valid_i = 4'b0010; bus.req_write_i = 4'b0000;
        bus.req_addr_i[10 +: 10] = 10'h155; bus.pready_i = 1'b0; bus.prdata_i = 32'h5555_5555;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL to_ready got %b exp 0010", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            checks++; if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o} !== 6'b110000) begin errors++; $display("FAIL to_access_%0d got %b exp 110000", i, {bus.psel_o, bus.penable_o, bus.rsp_valid_o}); end
        end
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid_o !== 4'b0010) begin errors++; $display("FAIL to_rsp_valid got %b exp 0010", bus.rsp_valid_o); end
        checks++; if (bus.rsp_err_o !== 1'b1) begin errors++; $display("FAIL to_rsp_err got %b exp 1", bus.rsp_err_o); end
        checks++; if (bus.rsp_data_o !== 32'd0) begin errors++; $display("FAIL to_rsp_data got %h exp 0", bus.rsp_data_o); end
        checks++; if ({bus.psel_o, bus.penable_o} !== 2'b00) begin errors++; $display("FAIL to_done_ctl got %b exp 00", {bus.psel_o, bus.penable_o}); end
        // Follow-up read must complete normally.
        @(negedge clk);
        bus.req_valid_i = 4'b1000; bus.req_addr_i[30 +: 10] = 10'h3FF;
        bus.pready_i = 1'b1; bus.prdata_i = 32'h1234_5678;
        #1;
        checks++; if (bus.req_ready_o !== 4'b1000) begin errors++; $display("FAIL to_next_ready got %b exp 1000", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 4'b0000;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid_o !== 4'b1000) begin errors++; $display("FAIL to_next_rsp got %b exp 1000", bus.rsp_valid_o); end
        checks++; if ({bus.rsp_err_o, bus.rsp_data_o} !== {1'b0, 32'h1234_5678}) begin errors++; $display("FAIL to_next_data got %h exp 012345678", {bus.rsp_err_o, bus.rsp_data_o}); end
    endtask

    task automatic test_slverr();
        @(negedge clk);
        bus.req_valid_i = 4'b0001; bus.req_write_i = 4'b0000;
        bus.pready_i = 1'b1; bus.pslverr_i = 1'b1; bus.prdata_i = 32'hCAFE_F00D;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL se_ready got %b exp 0001", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 4'b0000;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL se_rsp_valid got %b exp 0001", bus.rsp_valid_o); end
        checks++; if ({bus.rsp_err_o, bus.rsp_data_o} !== {1'b1, 32'd0}) begin errors++; $display("FAIL se_rsp got %h exp 100000000", {bus.rsp_err_o, bus.rsp_data_o}); end
        bus.pslverr_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid_i = 4'b0010; bus.req_write_i = 4'b0000; bus.pready_i = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL rm_ready got %b exp 0010", bus.req_ready_o); end
        @(negedge clk); bus.req_valid_i = 4'b0000;
        @(negedge clk); #1;
        checks++; if ({bus.psel_o, bus.penable_o} !== 2'b11) begin errors++; $display("FAIL rm_access got %b exp 11", {bus.psel_o, bus.penable_o}); end
        @(negedge clk); reset = 1'b1; bus.req_valid_i = 4'b1011; #1;
        checks++; if ({bus.psel_o, bus.penable_o} !== 2'b00) begin errors++; $display("FAIL rm_apb_drop got %b exp 00", {bus.psel_o, bus.penable_o}); end
        checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL rm_ready_forced got %b exp 0000", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL rm_rsp_in_reset got %b exp 0000", bus.rsp_valid_o); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL rm_first_winner got %b exp 0001", bus.req_ready_o); end
        bus.pready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.req_valid_i = 4'b0000; #1;
            checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL rm_no_stale_%0d got %b exp 0000", i, bus.rsp_valid_o); end
        end
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL rm_post_rsp got %b exp 0001", bus.rsp_valid_o); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.req_valid_i = '0;
        bus.req_write_i = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
